// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
// Handshake: the master holds mem_req, mem_we, mem_addr, mem_be and mem_wdata stable
// while mem_req=1; an access completes on the first rising edge where
// mem_req=1 and mem_ready=1, and mem_rdata is valid only on that cycle.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one access per core request, byte-lane formatting, bounded wait on
// the memory ready handshake, and a core stall held until the access retires.
module lsu #(
  parameter int unsigned MAXWAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [1:0]  dbg_state,
  lsu_if.master       mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] MAXW = 8'(MAXWAIT);

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] maddr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        legal;
  logic [3:0]  be_d;
  logic [31:0] wd_d;
  logic [31:0] shifted;
  logic [31:0] load_fmt;
  logic        timeout;

  // Stores only exist in b/h/w flavours; unsigned variants are load-only.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~req_write;
      3'b101:  legal = ~req_write & ~addr[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be_d = 4'b1111;
    wd_d = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_d = 4'b0001 << addr[1:0];
        wd_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_d = 4'b0011 << addr[1:0];
        wd_d = {2{wdata[15:0]}};
      end
      default: begin
        be_d = 4'b1111;
        wd_d = wdata;
      end
    endcase
  end

  always_comb begin
    shifted  = mem.mem_rdata >> {off_q, 3'b000};
    load_fmt = shifted;
    case (f3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {24'h0, shifted[7:0]};
      3'b101:  load_fmt = {16'h0, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  assign timeout = ~mem.mem_ready && (cnt_q == MAXW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = legal ? S_BUSY : S_DONE;
      S_BUSY:  if (mem.mem_ready || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      maddr_q <= 32'h0;
      be_q    <= 4'b0000;
      wd_q    <= 32'h0;
      cnt_q   <= 8'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else if (state_q == S_IDLE && req_valid) begin
      if (legal) begin
        we_q    <= req_write;
        f3_q    <= funct3;
        off_q   <= addr[1:0];
        maddr_q <= {addr[31:2], 2'b00};
        be_q    <= be_d;
        wd_q    <= wd_d;
        cnt_q   <= 8'h0;
        err_q   <= 1'b0;
      end else begin
        err_q   <= 1'b1;
        rdata_q <= 32'h0;
      end
    end else if (state_q == S_BUSY) begin
      if (mem.mem_ready) begin
        rdata_q <= we_q ? 32'h0 : load_fmt;
        err_q   <= 1'b0;
      end else if (timeout) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b1;
      end else begin
        cnt_q   <= cnt_q + 8'd1;
      end
    end
  end

  assign stall         = (state_q == S_IDLE && req_valid) || (state_q == S_BUSY);
  assign done          = (state_q == S_DONE);
  assign err           = done & err_q;
  assign rdata         = rdata_q;
  assign dbg_state     = state_q;
  assign mem.mem_req   = (state_q == S_BUSY);
  assign mem.mem_we    = (state_q == S_BUSY) & we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wd_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: behavioural memory with programmable wait count, reference model of
// legality, lane formatting and load extension, and a result scoreboard.
module tb_lsu;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic [1:0]  dbg_state;

  lsu_if mif();

  lsu #(.MAXWAIT(MAXW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .dbg_state (dbg_state),
    .mem       (mif)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic bit model_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000: return 1'b1;
      3'b001: return a[0] == 1'b0;
      3'b010: return a[1:0] == 2'b00;
      3'b100: return !we;
      3'b101: return !we && a[0] == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    be = 4'b0000;
    if (f3[1:0] == 2'b00) be[a[1:0]] = 1'b1;
    else if (f3[1:0] == 2'b01) be = a[1] ? 4'b1100 : 4'b0011;
    else be = 4'b1111;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (f3[1:0] == 2'b01) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [7:0]  bytes [4];
    logic [7:0]  b;
    logic [15:0] h;
    bytes[0] = w[7:0];
    bytes[1] = w[15:8];
    bytes[2] = w[23:16];
    bytes[3] = w[31:24];
    b = bytes[a[1:0]];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return b[7]  ? {24'hFFFFFF, b} : {24'h0, b};
      3'b001:  return h[15] ? {16'hFFFF, h}   : {16'h0, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // driver: one access, memory answers after nwait not-ready BUSY cycles
  task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rword, input int nwait);
    bit          legal, tmo, got_done;
    int          busy_cnt, stall_cnt, exp_busy, exp_stall;
    logic [32:0] exp;
    logic [68:0] exp_bus;
    legal     = model_legal(we, f3, a);
    tmo       = legal && nwait > MAXW;
    exp       = (!legal || tmo) ? {1'b1, 32'h0} : {1'b0, (we ? 32'h0 : model_load(f3, a, rword))};
    exp_bus   = {we, a[31:2], 2'b00, model_be(f3, a), model_wdata(f3, wd)};
    exp_busy  = !legal ? 0 : (tmo ? MAXW + 1 : nwait + 1);
    exp_stall = !legal ? 1 : exp_busy + 1;
    busy_cnt  = 0;
    stall_cnt = 0;
    got_done  = 1'b0;

    @(negedge clk);
    req_valid = 1'b1;
    req_write = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    mif.mem_ready = 1'($urandom_range(0, 1));
    mif.mem_rdata = $urandom;
    exp_q.push_back(exp);
    #1;
    if (stall) stall_cnt++;

    for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
      @(posedge clk);
      #1;
      if (mif.mem_req) begin
        busy_cnt++;
        check("bus_hold", 96'({mif.mem_we, mif.mem_addr, mif.mem_be, mif.mem_wdata}), 96'(exp_bus));
        if (busy_cnt > nwait) begin
          mif.mem_ready = 1'b1;
          mif.mem_rdata = rword;
        end else begin
          mif.mem_ready = 1'b0;
          mif.mem_rdata = $urandom;
        end
      end else begin
        mif.mem_ready = 1'($urandom_range(0, 1));
        mif.mem_rdata = $urandom;
      end
      if (stall) stall_cnt++;
      if (done) begin
        got_done  = 1'b1;
        req_valid = 1'b0;
        check("result", 96'({err, rdata}), 96'(exp_q.pop_front()));
      end
    end

    if (!got_done) begin
      check("done_wait_bound", 96'(0), 96'(1));
      req_valid = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    check("stall_cycles", 96'(stall_cnt), 96'(exp_stall));
    check("busy_cycles", 96'(busy_cnt), 96'(exp_busy));
    @(posedge clk);
    #1;
    check("done_one_cycle", 96'(done), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bit          r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_a;

    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    funct3 = 3'b000;
    addr = 32'h0;
    wdata = 32'h0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'h0;
    #12;
    check("rst_core_out", 96'({stall, done, err, rdata}), 96'(0));
    check("rst_mem_ctl", 96'({mif.mem_req, mif.mem_we, mif.mem_be}), 96'(0));
    check("rst_mem_data", 96'({mif.mem_addr, mif.mem_wdata}), 96'(0));
    check("rst_state", 96'(dbg_state), 96'(0));
    @(negedge clk);
    reset = 1'b1;

    // directed cases
    run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
    check("lb_value", 96'(rdata), 96'(32'hFFFF_FF80));
    run_access(1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'h0, 3);
    run_access(1'b0, 3'b101, 32'h0000_0040, 32'h0, 32'h0000_9ABC, 1);
    check("lhu_value", 96'(rdata), 96'(32'h0000_9ABC));
    run_access(1'b0, 3'b001, 32'h0000_0040, 32'h0, 32'h0000_9ABC, 0);
    check("lh_value", 96'(rdata), 96'(32'hFFFF_9ABC));
    run_access(1'b0, 3'b010, 32'h0000_0041, 32'h0, 32'h5555_5555, 0);
    run_access(1'b1, 3'b100, 32'h0000_0044, 32'h0000_DEAD, 32'h0, 0);
    run_access(1'b0, 3'b010, 32'h0000_0080, 32'h0, 32'h1122_3344, 10);
    check("timeout_rdata", 96'(rdata), 96'(0));
    run_access(1'b0, 3'b010, 32'h0000_0084, 32'h0, 32'hCAFE_F00D, 2);
    check("after_timeout_value", 96'(rdata), 96'(32'hCAFE_F00D));
    run_access(1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h00A5_0000, 0);
    run_access(1'b1, 3'b000, 32'h0000_0201, 32'hFFFF_FF7E, 32'h0, 4);

    // random mix
    for (int i = 0; i < 24; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
      run_access(r_we, r_f3, r_a, $urandom, $urandom, $urandom_range(0, 5));
    end

    // reset while an access is waiting on memory
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    funct3 = 3'b010;
    addr = 32'h0000_0200;
    mif.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_reset", 96'(mif.mem_req), 96'(1));
    reset = 1'b0;
    #1;
    check("reset_drops_req", 96'(mif.mem_req), 96'(0));
    check("reset_state_idle", 96'(dbg_state), 96'(0));
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("no_done_after_reset", 96'(seen), 96'(0));
    run_access(1'b0, 3'b000, 32'h0000_0301, 32'h0, 32'h0000_7F00, 1);
    check("post_reset_value", 96'(rdata), 96'(32'h0000_007F));

    check("scoreboard_empty", 96'(exp_q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
